h80cpu_uart_rx: RTL
===================

Name: h80cpu_uart_rx

Overview:
- UART receiver I/O responder on the h80cpu IO bus. It is the receive-side counterpart of the existing UART TX path.
- Deserialises 8N1 frames from an `rxd` pin into a small FIFO.
- Answers CPU bus read/write requests through the standard run/done toggle handshake.
- Instantiated inside h80cpu_io, which decodes the IO address range and routes this block its own run/done pair.

Parameters:
- CLK_FREQ, 27000000, clk frequency in Hz.
- BAUD, 115200, line rate. BIT_DIV = CLK_FREQ/BAUD, truncated.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- addr  in  16 (bus_addr_t)  byte address; only addr[1:0] is used.
- cmd  in  3 (bus_cmd_t)  read_w / write_w / read_b / write_b.
- run  in  1  request toggle from CPU.
- wr_data  in  16 (bus_data_t)  write data.
- rd_data  out  16 (bus_data_t)  read data.
- done  out  1  acknowledge toggle.
- rxd  in  1  asynchronous serial input, idle high.

Behaviour:
- Reset:
  - done=0, rd_data=0.
  - FIFO emptied; ovr, ferr (and perr) flags cleared.
  - RX FSM forced to IDLE; any frame in progress is aborted.
  - rxd synchroniser preset to 1.
- Bus handshake:
  - A request is pending when run != done.
  - The block services it on the next posedge: rd_data and done toggle on the same edge, so latency is 1 clk.
  - Exactly one response per toggle; no response while run == done.
- Register map, word registers selected by addr[1]:
  - DATA (addr[1]=0), read:
    - FIFO non-empty → {1'b1 valid, 7'b0, byte}; one entry is popped.
    - FIFO empty → 0x0000; no pop.
  - DATA, write: ignored.
  - STATUS (addr[1]=1), read: {12'b0, perr, ferr, ovr, nonempty}; no side effects.
  - STATUS, write: write-1-to-clear on bits[3:1]; bit0 is read-only.
- Byte commands:
  - read_b returns {8'h00, selected half}; addr[0]=1 selects bits[15:8].
  - read_b of DATA at addr[0]=0 pops; read_b at addr[0]=1 does not pop.
  - write_b acts on bits[7:0] only when addr[0]=0.
- Input path: rxd passes through a 2-flop synchroniser.
- RX FSM:
  - IDLE: a synchronised low moves to START and loads the bit counter with BIT_DIV/2.
  - START: when the counter expires, line still low → DATA with bitcnt=0; line high → glitch, return to IDLE.
  - DATA: sample every BIT_DIV clocks, LSB first. After 8 samples go to STOP (or PARITY when the optional feature is enabled).
  - STOP: sample the line.
    - High → push the byte.
    - Low → set ferr and discard the byte; stay in STOP until the line is high, then go to IDLE.
    - The byte is pushed, or discarded, on the stop-sample cycle itself.
- FIFO push and pop:
  - Push while full with no simultaneous pop → ovr=1; the new byte is dropped and FIFO contents are kept.
  - Push and pop in the same clk → both succeed. Count is unchanged and ovr is not set, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
  - STATUS write-1-to-clear and a new error event in the same clk → the flag ends up set.

Optional Feature:
- Macro: H80CPU_UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is sampled in a PARITY state between DATA and STOP.
  - On mismatch, perr is set and the byte is discarded even if the stop bit is good.
- Undefined:
  - Plain 8N1; perr reads as 0.
  - No PARITY state exists.

Decomposition:
- Shared package/header (h80cpu.svh): bus_addr_t, bus_data_t, bus_cmd_t and its encodings.
- Add to the same header:
  - UART RX register offsets (UART_RX_DATA, UART_RX_STAT).
  - Status bit indices (uart_rx_stat_nonempty, _ovr, _ferr, _perr).
  - Data valid bit index (15).
- Sub-module h80cpu_fifo:
  - Synchronous FIFO parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Simultaneous push and pop are legal when full.

Test Plan (CLK_FREQ=1600000, BAUD=100000, so BIT_DIV=16):
- Frame 0x55 on rxd, then read_w DATA → STATUS reads 0x0001 before the read. DATA returns 0x8055. STATUS then reads 0x0000.
- read_w DATA while empty → 0x0000; done toggles exactly once, 1 clk after run toggles.
- Five frames 0x01..0x05 with no reads (depth 4):
  - STATUS reads 0x0003.
  - Four reads return 0x8001..0x8004, then 0x0000.
  - write_w STATUS 0x0002 clears ovr.
- Frame 0xA5 with stop bit driven low → ferr set (STATUS 0x0004), FIFO stays empty. Next good frame 0x3C is received correctly.
- rxd low pulse of 4 clks → no byte, FSM back to IDLE. Separately, assert reset mid-DATA → FIFO empty, STATUS 0x0000, done=0.
- With H80CPU_UART_RX_PARITY_EN: frame 0x07 with parity bit 0 → perr set (STATUS 0x0008), byte discarded. Same frame with parity bit 1 → DATA reads 0x8007.

Source files
------------

// File: rtl/h80cpu_uart_rx_pkg.sv
// Shared h80cpu IO bus types plus UART RX register offsets, status bit indices and RX FSM states.
// PARITY state only exists when H80CPU_UART_RX_PARITY_EN is defined.
package h80cpu_uart_rx_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;

    typedef enum logic [2:0] {
        BUS_NOP     = 3'd0,
        BUS_READ_W  = 3'd1,
        BUS_WRITE_W = 3'd2,
        BUS_READ_B  = 3'd3,
        BUS_WRITE_B = 3'd4
    } bus_cmd_t;

    localparam bus_addr_t UART_RX_DATA = 16'h0000;
    localparam bus_addr_t UART_RX_STAT = 16'h0002;

    localparam int UART_RX_STAT_NONEMPTY = 0;
    localparam int UART_RX_STAT_OVR      = 1;
    localparam int UART_RX_STAT_FERR     = 2;
    localparam int UART_RX_STAT_PERR     = 3;
    localparam int UART_RX_DATA_VALID    = 15;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef H80CPU_UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/h80cpu_fifo.sv
// Synchronous FIFO, combinational read of the head entry; push while full is dropped
// unless a pop happens in the same clock, in which case both succeed.
module h80cpu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/h80cpu_uart_rx.sv
// UART 8N1 receiver on the h80cpu IO bus (even parity with H80CPU_UART_RX_PARITY_EN); 1-clk
// run/done toggle response; a full FIFO drops new bytes and sets ovr instead of stalling.
module h80cpu_uart_rx
    import h80cpu_uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  bus_addr_t addr,
    input  bus_cmd_t  cmd,
    input  logic      run,
    input  bus_data_t wr_data,
    output bus_data_t rd_data,
    output logic      done,
    input  logic      rxd
);
    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_DIV - 1);

    logic            rxd_s1_q, rxd_s2_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_err_q, stop_err_d;
    logic            par_bad_q, par_bad_d;
    logic            ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
    logic            done_q, done_d;
    bus_data_t       rd_data_q, rd_data_d;

    logic            rx_in, cnt_zero, byte_ok, ferr_set, perr_set, ovr_set;
    logic            pending, is_rd, is_wr, is_byte;
    logic [2:0]      clr;
    bus_data_t       status_word, data_word, sel_word;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic            unused_bits;

    assign rx_in       = rxd_s2_q;
    assign cnt_zero    = (cnt_q == '0);
    assign unused_bits = ^{addr[15:2], wr_data[15:4], wr_data[0]};

    h80cpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        stop_err_d = stop_err_q;
        par_bad_d  = par_bad_q;
        byte_ok    = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
        case (state_q)
            RX_IDLE: if (!rx_in) begin
                state_d = RX_START;
                cnt_d   = CNT_HALF;
            end
            RX_START: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else if (rx_in) state_d = RX_IDLE;
                else begin
                    state_d    = RX_DATA;
                    bitcnt_d   = 3'd0;
                    cnt_d      = CNT_FULL;
                    stop_err_d = 1'b0;
                    par_bad_d  = 1'b0;
                end
            RX_DATA: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else begin
                    shift_d  = {rx_in, shift_q[7:1]};
                    cnt_d    = CNT_FULL;
                    bitcnt_d = bitcnt_q + 3'd1;
`ifdef H80CPU_UART_RX_PARITY_EN
                    if (bitcnt_q == 3'd7) state_d = RX_PARITY;
`else
                    if (bitcnt_q == 3'd7) state_d = RX_STOP;
`endif
                end
`ifdef H80CPU_UART_RX_PARITY_EN
            RX_PARITY: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else begin
                    par_bad_d = (rx_in != even_parity(shift_q));
                    perr_set  = par_bad_d;
                    cnt_d     = CNT_FULL;
                    state_d   = RX_STOP;
                end
`endif
            RX_STOP: if (stop_err_q) begin
                    // Hold here through a broken stop bit so its low level is not seen as a new start.
                    if (rx_in) begin
                        state_d    = RX_IDLE;
                        stop_err_d = 1'b0;
                    end
                end else if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else if (rx_in) begin
                    byte_ok = !par_bad_q;
                    state_d = RX_IDLE;
                end else begin
                    ferr_set   = 1'b1;
                    stop_err_d = 1'b1;
                end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        pending  = (run != done_q);
        is_rd    = (cmd == BUS_READ_W)  || (cmd == BUS_READ_B);
        is_wr    = (cmd == BUS_WRITE_W) || (cmd == BUS_WRITE_B);
        is_byte  = (cmd == BUS_READ_B)  || (cmd == BUS_WRITE_B);

        status_word = '0;
        status_word[UART_RX_STAT_NONEMPTY] = !fifo_empty;
        status_word[UART_RX_STAT_OVR]      = ovr_q;
        status_word[UART_RX_STAT_FERR]     = ferr_q;
        status_word[UART_RX_STAT_PERR]     = perr_q;
        data_word = '0;
        if (!fifo_empty) data_word = {1'b1, 7'b0, fifo_dout};
        sel_word = addr[1] ? status_word : data_word;

        fifo_pop  = pending && is_rd && !addr[1] && !fifo_empty && (!is_byte || !addr[0]);
        fifo_push = byte_ok && (!fifo_full || fifo_pop);
        ovr_set   = byte_ok && fifo_full && !fifo_pop;

        clr = 3'b000;
        if (pending && is_wr && addr[1] && (!is_byte || !addr[0])) clr = wr_data[3:1];
        ovr_d  = (ovr_q  & ~clr[0]) | ovr_set;
        ferr_d = (ferr_q & ~clr[1]) | ferr_set;
        perr_d = (perr_q & ~clr[2]) | perr_set;

        done_d    = pending ? ~done_q : done_q;
        rd_data_d = rd_data_q;
        if (pending && is_rd)
            rd_data_d = is_byte ? {8'h00, (addr[0] ? sel_word[15:8] : sel_word[7:0])} : sel_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            par_bad_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            stop_err_q <= stop_err_d;
            par_bad_q  <= par_bad_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule
